// File: rtl/ysyx_24100006_rf_wb_arbiter_if.sv
// rtl/ysyx_24100006_rf_wb_arbiter_if.sv - writeback requests, register-file write and busy-scoreboard signals
interface ysyx_24100006_rf_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  exu_valid;
  logic                  exu_ready;
  logic [ADDR_WIDTH-1:0] exu_waddr;
  logic [DATA_WIDTH-1:0] exu_wdata;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_waddr;
  logic [DATA_WIDTH-1:0] lsu_wdata;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  sb_set_valid;
  logic [ADDR_WIDTH-1:0] sb_set_addr;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  wb_idle;

  modport master (
    output exu_valid, exu_waddr, exu_wdata,
    output lsu_valid, lsu_waddr, lsu_wdata,
    output sb_set_valid, sb_set_addr, rs1, rs2,
    input  exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata,
    input  rs1_busy, rs2_busy, wb_idle
  );

  modport slave (
    input  exu_valid, exu_waddr, exu_wdata,
    input  lsu_valid, lsu_waddr, lsu_wdata,
    input  sb_set_valid, sb_set_addr, rs1, rs2,
    output exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata,
    output rs1_busy, rs2_busy, wb_idle
  );
endinterface

// File: rtl/ysyx_24100006_rf_wb_arbiter.sv
// rtl/ysyx_24100006_rf_wb_arbiter.sv - round-robin EXU/LSU writeback arbiter with registered
// register-file write stage and per-register busy scoreboard
module ysyx_24100006_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic                          clk,
  input logic                          rst_n,
  ysyx_24100006_rf_wb_arbiter_if.slave bus
);
  localparam int   NUM_REGS  = 1 << ADDR_WIDTH;
  localparam logic GRANT_EXU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  logic                  last_grant;
  logic                  grant_exu;
  logic                  grant_lsu;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (bus.exu_valid && bus.lsu_valid) begin
      if (last_grant == GRANT_LSU) grant_exu = 1'b1;
      else                         grant_lsu = 1'b1;
    end else if (bus.exu_valid) begin
      grant_exu = 1'b1;
    end else if (bus.lsu_valid) begin
      grant_lsu = 1'b1;
    end
  end

  assign handshake = grant_exu | grant_lsu;
  assign sel_addr  = grant_lsu ? bus.lsu_waddr : bus.exu_waddr;
  assign sel_data  = grant_lsu ? bus.lsu_wdata : bus.exu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_LSU;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (handshake) begin
      last_grant <= grant_lsu ? GRANT_LSU : GRANT_EXU;
      rf_wen_q   <= (sel_addr != '0);
      rf_waddr_q <= sel_addr;
      rf_wdata_q <= sel_data;
    end else begin
      rf_wen_q   <= 1'b0;
    end
  end

  // Clear is applied first so a same-edge set for a new writer wins.
  always_comb begin
    busy_next = busy;
    if (rf_wen_q) busy_next[rf_waddr_q] = 1'b0;
    if (bus.sb_set_valid && (bus.sb_set_addr != '0)) busy_next[bus.sb_set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign bus.exu_ready = grant_exu;
  assign bus.lsu_ready = grant_lsu;
  assign bus.rf_wen    = rf_wen_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.rs1_busy  = busy[bus.rs1];
  assign bus.rs2_busy  = busy[bus.rs2];
  assign bus.wb_idle   = ~|busy & ~rf_wen_q;
endmodule

// File: tb/tb_ysyx_24100006_rf_wb_arbiter.sv
// tb/tb_ysyx_24100006_rf_wb_arbiter.sv - scoreboard bench with reference model for the writeback arbiter
module tb_ysyx_24100006_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_24100006_rf_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();
  ysyx_24100006_rf_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic        er;
    logic        lr;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        b1;
    logic        b2;
    logic        idle;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Reference model: architectural view of who wins, what lands in the RF, and which regs are pending.
  bit          mbusy[32];
  bit          mlast_lsu;
  bit          mwen;
  logic [4:0]  mwa;
  logic [31:0] mwd;
  bit          pend_e, pend_l;

  logic        ev, lv, sv;
  logic [4:0]  ea, la, sa, r1, r2;
  logic [31:0] ed, ld;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endfunction

  function automatic void model_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mlast_lsu = 1'b1;
    mwen      = 1'b0;
    mwa       = '0;
    mwd       = '0;
    pend_e    = 1'b0;
    pend_l    = 1'b0;
  endfunction

  function automatic bit model_idle();
    foreach (mbusy[i]) if (mbusy[i]) return 1'b0;
    return !mwen;
  endfunction

  task automatic step(input logic i_ev, input logic [4:0] i_ea, input logic [31:0] i_ed,
                      input logic i_lv, input logic [4:0] i_la, input logic [31:0] i_ld,
                      input logic i_sv, input logic [4:0] i_sa,
                      input logic [4:0] i_r1, input logic [4:0] i_r2);
    exp_t e;
    bit   g_e, g_l;
    @(posedge clk);
    #1;
    bus.exu_valid = i_ev; bus.exu_waddr = i_ea; bus.exu_wdata = i_ed;
    bus.lsu_valid = i_lv; bus.lsu_waddr = i_la; bus.lsu_wdata = i_ld;
    bus.sb_set_valid = i_sv; bus.sb_set_addr = i_sa;
    bus.rs1 = i_r1; bus.rs2 = i_r2;
    g_e = i_ev && (!i_lv || mlast_lsu);
    g_l = i_lv && !g_e;
    e.er = g_e; e.lr = g_l; e.wen = mwen; e.wa = mwa; e.wd = mwd;
    e.b1 = mbusy[i_r1]; e.b2 = mbusy[i_r2]; e.idle = model_idle();
    exp_q.push_back(e);
    mon_en = 1'b1;
    if (mwen) mbusy[mwa] = 1'b0;
    if (i_sv && i_sa != 0) mbusy[i_sa] = 1'b1;
    if (g_e || g_l) begin
      mwa = g_e ? i_ea : i_la;
      mwd = g_e ? i_ed : i_ld;
      mwen = (mwa != 0);
      mlast_lsu = g_l;
    end else begin
      mwen = 1'b0;
    end
    pend_e = i_ev && !g_e;
    pend_l = i_lv && !g_l;
  endtask

  task automatic idle_step(input logic [4:0] i_r1, input logic [4:0] i_r2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, i_r1, i_r2);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("exu_ready", {31'd0, bus.exu_ready}, {31'd0, e.er});
        chk("lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, e.lr});
        chk("rf_wen",    {31'd0, bus.rf_wen},    {31'd0, e.wen});
        chk("rf_waddr",  {27'd0, bus.rf_waddr},  {27'd0, e.wa});
        chk("rf_wdata",  bus.rf_wdata,           e.wd);
        chk("rs1_busy",  {31'd0, bus.rs1_busy},  {31'd0, e.b1});
        chk("rs2_busy",  {31'd0, bus.rs2_busy},  {31'd0, e.b2});
        chk("wb_idle",   {31'd0, bus.wb_idle},   {31'd0, e.idle});
      end
    end
  end

  // Asserts reset mid-cycle and checks outputs settle before the next clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    @(posedge clk);
    #2;
    bus.exu_valid = 1'b0; bus.lsu_valid = 1'b0; bus.sb_set_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rf_wen",   {31'd0, bus.rf_wen},   32'd0);
    chk("rst_rf_waddr", {27'd0, bus.rf_waddr}, 32'd0);
    chk("rst_rf_wdata", bus.rf_wdata,          32'd0);
    chk("rst_rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
    chk("rst_rs2_busy", {31'd0, bus.rs2_busy}, 32'd0);
    chk("rst_wb_idle",  {31'd0, bus.wb_idle},  32'd1);
    model_reset();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.exu_valid = 1'b0; bus.exu_waddr = '0; bus.exu_wdata = '0;
    bus.lsu_valid = 1'b0; bus.lsu_waddr = '0; bus.lsu_wdata = '0;
    bus.sb_set_valid = 1'b0; bus.sb_set_addr = '0;
    bus.rs1 = '0; bus.rs2 = '0;
    model_reset();
    #12;
    chk("init_rf_wen",  {31'd0, bus.rf_wen},  32'd0);
    chk("init_wb_idle", {31'd0, bus.wb_idle}, 32'd1);
    #10;
    rst_n = 1'b1;

    // Three busy bits and a write in flight, then reset mid-stream.
    step(1'b1, 5'd9, 32'hdead_beef, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 5'd12, 5'd13);
    step(1'b1, 5'd15, 32'h0bad_f00d, 1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 5'd12, 5'd13);
    mid_reset();

    // EXU alone, one-cycle latency, single pulse.
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
    idle_step(5'd5, 5'd0);
    idle_step(5'd5, 5'd0);
    mid_reset();

    // Both valid for four cycles from a fresh reset: EXU, LSU, EXU, LSU.
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd10, 32'haaaa_0001, 1'b1, 5'd11, 32'hbbbb_0002, 1'b0, 5'd0, 5'd10, 5'd11);
    idle_step(5'd0, 5'd0);
    idle_step(5'd0, 5'd0);

    // Busy tracks x7 until the RF write edge.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    step(1'b1, 5'd7, 32'h7777_7777, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    idle_step(5'd7, 5'd0);
    idle_step(5'd7, 5'd0);

    // Set and clear of x3 on the same edge: set wins.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    step(1'b1, 5'd3, 32'h3333_3333, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    idle_step(5'd3, 5'd0);
    idle_step(5'd3, 5'd0);

    // LSU write to x0 and a set of x0 are both no-ops on RF enable and busy.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555_5555, 1'b1, 5'd0, 5'd0, 5'd3);
    idle_step(5'd0, 5'd3);
    idle_step(5'd0, 5'd0);

    // Randomized traffic; a losing requester keeps its request stable.
    ev = 1'b0; lv = 1'b0; ea = '0; la = '0; ed = '0; ld = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend_e) begin
        ev = ($urandom_range(0, 2) != 0);
        ea = 5'($urandom_range(0, 31));
        ed = $urandom;
      end
      if (!pend_l) begin
        lv = ($urandom_range(0, 2) != 0);
        la = 5'($urandom_range(0, 31));
        ld = $urandom;
      end
      sa = 5'($urandom_range(0, 31));
      sv = ($urandom_range(0, 2) == 0) && !mbusy[sa];
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      step(ev, ea, ed, lv, la, ld, sv, sa, r1, r2);
    end
    idle_step(5'd0, 5'd0);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
